// File: rtl/matmul_pkg.sv
// Shared state type, default sizes and arithmetic helpers for matmul_stream_engine.
package matmul_pkg;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        COMPUTE,
        OUTPUT
    } state_e;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_M      = 4;
    localparam int DEF_K      = 4;
    localparam int DEF_N      = 4;

    // Address width for a RAM of the given depth; depth 1 still needs one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Signed add of two sign-extended operands, clamped to a w-bit signed range.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w
    );
        logic signed [64:0] s;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        s  = {a[63], a} + {b[63], b};
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (w - 1));
        if (s > hi) begin
            return hi[63:0];
        end
        if (s < lo) begin
            return lo[63:0];
        end
        return s[63:0];
    endfunction

endpackage

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: one write port, one read port with a 1-cycle registered read.
module dual_port_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/matmul_stream_engine_mac.sv
// Multiply-accumulate stage; MATMUL_SATURATE_EN selects sticky clamping
// instead of modulo-2^ACC_W wrap.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 34
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [ACC_W-1:0]  acc_o
);

    logic [ACC_W-1:0]          acc_q;
    logic [ACC_W-1:0]          acc_d;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [63:0]        p64;
    logic signed [63:0]        a64;
    logic signed [63:0]        sum64;
`ifdef MATMUL_SATURATE_EN
    logic                      sat_q;
    logic                      sat_d;
    logic signed [63:0]        sat64;
`endif

    always_comb begin
        prod  = $signed(a_i) * $signed(b_i);
        p64   = 64'(prod);
        a64   = clr_i ? 64'sd0 : 64'($signed(acc_q));
        sum64 = a64 + p64;
        acc_d = ACC_W'(sum64);
`ifdef MATMUL_SATURATE_EN
        sat64 = sat_add(a64, p64, ACC_W);
        acc_d = ACC_W'(sat64);
        sat_d = (sat64 != sum64);
        // Once clamped, the element holds its rail until the next clear.
        if (sat_q && !clr_i) begin
            acc_d = acc_q;
            sat_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
`ifdef MATMUL_SATURATE_EN
            sat_q <= 1'b0;
`endif
        end else if (en_i) begin
            acc_q <= acc_d;
`ifdef MATMUL_SATURATE_EN
            sat_q <= sat_d;
`endif
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/matmul_stream_engine.sv
// AXI-Stream matrix multiplier C = A*B over three dual_port_ram banks.
// Optional MATMUL_SATURATE_EN clamps accumulation instead of wrapping.
module matmul_stream_engine
    import matmul_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int M      = DEF_M,
    parameter int K      = DEF_K,
    parameter int N      = DEF_N,
    parameter int ACC_W  = 2 * DATA_W + $clog2(K)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_axis_valid,
    output logic              s_axis_ready,
    input  logic [DATA_W-1:0] s_axis_data,
    input  logic              s_axis_last,
    output logic              m_axis_valid,
    input  logic              m_axis_ready,
    output logic [ACC_W-1:0]  m_axis_data,
    output logic              m_axis_last,
    output logic              busy,
    output logic              frame_err,
    output logic              done
);

    localparam int DA  = M * K;
    localparam int DB  = K * N;
    localparam int DC  = M * N;
    localparam int AWA = addr_w(DA);
    localparam int AWB = addr_w(DB);
    localparam int AWC = addr_w(DC);
    localparam int LW  = addr_w((DA > DB) ? DA : DB);
    localparam int CW  = addr_w(DC + 1);
    localparam int IW  = addr_w(M);
    localparam int JW  = addr_w(N);
    localparam int KW  = addr_w(K);

    state_e            state_q;
    logic [LW-1:0]     ld_q;
    logic [KW-1:0]     k_q;
    logic [IW-1:0]     i_q;
    logic [JW-1:0]     j_q;
    logic [AWC-1:0]    e_q;
    logic              iss_q;
    logic              v1_q;
    logic              clr1_q;
    logic              last1_q;
    logic [AWC-1:0]    e1_q;
    logic              v2_q;
    logic [AWC-1:0]    e2_q;
    logic [CW-1:0]     rp_q;
    logic [AWC-1:0]    pidx_q;
    logic              pv_q;
    logic              ov_q;
    logic              ol_q;
    logic [ACC_W-1:0]  od_q;
    logic              rv_q;
    logic              rl_q;
    logic [ACC_W-1:0]  rd_q;
    logic              ferr_q;
    logic              done_q;

    logic              s_acc;
    logic              pop;
    logic              plast;
    logic              issue;
    logic [1:0]        occ;
    logic [AWA-1:0]    a_raddr;
    logic [AWB-1:0]    b_raddr;
    logic [DATA_W-1:0] a_rdata;
    logic [DATA_W-1:0] b_rdata;
    logic [ACC_W-1:0]  c_rdata;
    logic [ACC_W-1:0]  acc;

    assign s_axis_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign s_acc   = s_axis_valid && s_axis_ready;
    assign pop     = ov_q && m_axis_ready;
    assign plast   = (pidx_q == AWC'(DC - 1));
    assign occ     = {1'b0, ov_q} + {1'b0, rv_q} + {1'b0, pv_q};
    // Read ahead only while the output and read-ahead registers can absorb it.
    assign issue   = (state_q == OUTPUT) && (rp_q != CW'(DC))
                  && ((occ - {1'b0, pop}) <= 2'd1);
    assign a_raddr = AWA'(int'(i_q) * K + int'(k_q));
    assign b_raddr = AWB'(int'(k_q) * N + int'(j_q));

    dual_port_ram #(.WIDTH(DATA_W), .DEPTH(DA), .AW(AWA)) u_ram_a (
        .clk     (clk),
        .we_i    ((state_q == LOAD_A) && s_acc),
        .waddr_i (AWA'(ld_q)),
        .wdata_i (s_axis_data),
        .raddr_i (a_raddr),
        .rdata_o (a_rdata)
    );

    dual_port_ram #(.WIDTH(DATA_W), .DEPTH(DB), .AW(AWB)) u_ram_b (
        .clk     (clk),
        .we_i    ((state_q == LOAD_B) && s_acc),
        .waddr_i (AWB'(ld_q)),
        .wdata_i (s_axis_data),
        .raddr_i (b_raddr),
        .rdata_o (b_rdata)
    );

    dual_port_ram #(.WIDTH(ACC_W), .DEPTH(DC), .AW(AWC)) u_ram_c (
        .clk     (clk),
        .we_i    (v2_q),
        .waddr_i (e2_q),
        .wdata_i (acc),
        .raddr_i (AWC'(rp_q)),
        .rdata_o (c_rdata)
    );

    matmul_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk   (clk),
        .reset (reset),
        .en_i  (v1_q),
        .clr_i (clr1_q),
        .a_i   (a_rdata),
        .b_i   (b_rdata),
        .acc_o (acc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD_A;
            ld_q    <= '0;
            k_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            e_q     <= '0;
            iss_q   <= 1'b0;
            v1_q    <= 1'b0;
            clr1_q  <= 1'b0;
            last1_q <= 1'b0;
            e1_q    <= '0;
            v2_q    <= 1'b0;
            e2_q    <= '0;
            rp_q    <= '0;
            pidx_q  <= '0;
            pv_q    <= 1'b0;
            ov_q    <= 1'b0;
            ol_q    <= 1'b0;
            od_q    <= '0;
            rv_q    <= 1'b0;
            rl_q    <= 1'b0;
            rd_q    <= '0;
            ferr_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            v1_q   <= 1'b0;
            v2_q   <= v1_q && last1_q;
            e2_q   <= e1_q;
            unique case (state_q)
                LOAD_A: begin
                    if (s_acc) begin
                        if (ld_q == '0) begin
                            ferr_q <= 1'b0;
                        end
                        if (s_axis_last) begin
                            ferr_q <= 1'b1;
                            ld_q   <= '0;
                        end else if (ld_q == LW'(DA - 1)) begin
                            ld_q    <= '0;
                            state_q <= LOAD_B;
                        end else begin
                            ld_q <= ld_q + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (s_acc) begin
                        if (ld_q == LW'(DB - 1)) begin
                            if (!s_axis_last) begin
                                ferr_q <= 1'b1;
                            end
                            ld_q    <= '0;
                            k_q     <= '0;
                            i_q     <= '0;
                            j_q     <= '0;
                            e_q     <= '0;
                            iss_q   <= 1'b1;
                            state_q <= COMPUTE;
                        end else if (s_axis_last) begin
                            ferr_q  <= 1'b1;
                            ld_q    <= '0;
                            state_q <= LOAD_A;
                        end else begin
                            ld_q <= ld_q + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    // Reads for the next element start right behind the current one.
                    if (iss_q) begin
                        v1_q    <= 1'b1;
                        clr1_q  <= (k_q == '0);
                        last1_q <= (k_q == KW'(K - 1));
                        e1_q    <= e_q;
                        if (k_q == KW'(K - 1)) begin
                            k_q <= '0;
                            e_q <= e_q + 1'b1;
                            if (j_q == JW'(N - 1)) begin
                                j_q <= '0;
                                i_q <= i_q + 1'b1;
                                if (i_q == IW'(M - 1)) begin
                                    iss_q <= 1'b0;
                                end
                            end else begin
                                j_q <= j_q + 1'b1;
                            end
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                    if (v2_q && (e2_q == AWC'(DC - 1))) begin
                        rp_q    <= '0;
                        state_q <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (issue) begin
                        rp_q   <= rp_q + 1'b1;
                        pidx_q <= AWC'(rp_q);
                    end
                    pv_q <= issue;
                    if (!ov_q || pop) begin
                        if (rv_q) begin
                            ov_q <= 1'b1;
                            od_q <= rd_q;
                            ol_q <= rl_q;
                            rv_q <= pv_q;
                            rd_q <= c_rdata;
                            rl_q <= pv_q && plast;
                        end else begin
                            ov_q <= pv_q;
                            od_q <= c_rdata;
                            ol_q <= pv_q && plast;
                        end
                    end else if (pv_q) begin
                        rv_q <= 1'b1;
                        rd_q <= c_rdata;
                        rl_q <= plast;
                    end
                    if (pop && ol_q) begin
                        ov_q    <= 1'b0;
                        ol_q    <= 1'b0;
                        rv_q    <= 1'b0;
                        pv_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= LOAD_A;
                    end
                end
            endcase
        end
    end

    assign m_axis_valid = ov_q;
    assign m_axis_data  = od_q;
    assign m_axis_last  = ol_q;
    assign busy         = (state_q != LOAD_A);
    assign frame_err    = ferr_q;
    assign done         = done_q;

endmodule

// File: tb/tb_matmul_stream_engine.sv
// Scoreboard bench for matmul_stream_engine: a 34-bit and a 32-bit accumulator
// instance run in lockstep on the same streams.
module tb_matmul_stream_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic [15:0] s_data = '0;
    logic        m_ready = 1'b0;

    logic        s_ready, m_valid, m_last, busy, ferr, done;
    logic [33:0] m_data;
    logic        s_ready2, m_valid2, m_last2, busy2, ferr2, done2;
    logic [31:0] m_data2;

    int total = 0;
    int bad = 0;

    logic signed [15:0] A[16];
    logic signed [15:0] B[16];
    logic [33:0] exp34[$];
    logic [33:0] got34[$];
    logic [31:0] exp32[$];
    logic [31:0] got32[$];
    bit          expl[$];
    bit          gotl[$];
    int          held_bad, dones, tmo;

    always #5 clk = ~clk;

    matmul_stream_engine u_dut (
        .clk          (clk),
        .reset        (reset),
        .s_axis_valid (s_valid),
        .s_axis_ready (s_ready),
        .s_axis_data  (s_data),
        .s_axis_last  (s_last),
        .m_axis_valid (m_valid),
        .m_axis_ready (m_ready),
        .m_axis_data  (m_data),
        .m_axis_last  (m_last),
        .busy         (busy),
        .frame_err    (ferr),
        .done         (done)
    );

    matmul_stream_engine #(.ACC_W(32)) u_dut32 (
        .clk          (clk),
        .reset        (reset),
        .s_axis_valid (s_valid),
        .s_axis_ready (s_ready2),
        .s_axis_data  (s_data),
        .s_axis_last  (s_last),
        .m_axis_valid (m_valid2),
        .m_axis_ready (m_ready),
        .m_axis_data  (m_data2),
        .m_axis_last  (m_last2),
        .busy         (busy2),
        .frame_err    (ferr2),
        .done         (done2)
    );

    // Reference C for both accumulator widths from the current A and B.
    task automatic push_expected();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                longint acc, a32, p;
`ifdef MATMUL_SATURATE_EN
                longint s;
                bit st;
                st = 1'b0;
`endif
                acc = 0;
                a32 = 0;
                for (int k = 0; k < 4; k++) begin
                    p = longint'(A[i*4+k]) * longint'(B[k*4+j]);
                    acc += p;
`ifdef MATMUL_SATURATE_EN
                    s = a32 + p;
                    if (!st) begin
                        if (s > 64'sd2147483647) begin
                            a32 = 64'sd2147483647;
                            st = 1'b1;
                        end else if (s < -64'sd2147483648) begin
                            a32 = -64'sd2147483648;
                            st = 1'b1;
                        end else begin
                            a32 = s;
                        end
                    end
`else
                    a32 += p;
`endif
                end
                exp34.push_back(acc[33:0]);
                exp32.push_back(a32[31:0]);
                expl.push_back(i == 3 && j == 3);
            end
        end
    endtask

    task automatic send_frame(input int last_at, input int nbeats, output int to);
        to = 0;
        for (int n = 1; n <= nbeats; n++) begin
            s_valid = 1'b1;
            if (n <= 16) s_data = A[n-1];
            else s_data = B[n-17];
            s_last = (n == last_at);
            @(negedge clk);
            for (int w = 0; w < 100 && !s_ready; w++) @(negedge clk);
            if (!s_ready) to++;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic collect(input int n, input bit toggle);
        int got, cyc;
        bit stall;
        logic [33:0] pd;
        logic pl;
        got = 0; cyc = 0; stall = 1'b0; pd = '0; pl = 1'b0;
        held_bad = 0; dones = 0; tmo = 0;
        got34.delete(); got32.delete(); gotl.delete();
        while (got < n && cyc < 3000) begin
            m_ready = toggle ? cyc[0] : 1'b1;
            @(negedge clk);
            if (done) dones++;
            if (stall && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl))
                held_bad++;
            stall = 1'b0;
            if (m_valid && m_ready) begin
                got34.push_back(m_data);
                got32.push_back(m_valid2 ? m_data2 : 32'hxxxx_xxxx);
                gotl.push_back(m_last);
                got++;
            end else if (m_valid) begin
                stall = 1'b1;
                pd = m_data;
                pl = m_last;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        m_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
            @(posedge clk);
            #1;
        end
        if (got < n) tmo = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want 1", s_ready); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", m_valid); end
        total++; if (m_data !== 34'd0) begin bad++; $display("FAIL rst_data got %h want 0", m_data); end
        total++; if (m_last !== 1'b0) begin bad++; $display("FAIL rst_last got %b want 0", m_last); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
        total++; if (ferr !== 1'b0) begin bad++; $display("FAIL rst_ferr got %b want 0", ferr); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got %b want 0", done); end
        total++;
        if ({s_ready2, m_valid2, m_last2, busy2, ferr2, done2, m_data2} !== {6'b100000, 32'd0}) begin
            bad++; $display("FAIL rst_dut32 got %b/%h want 100000/0",
                {s_ready2, m_valid2, m_last2, busy2, ferr2, done2}, m_data2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_identity();
        int to;
        logic [33:0] e34; logic [31:0] e32; bit el;
        for (int x = 0; x < 16; x++) begin
            A[x] = (x % 5 == 0) ? 16'sd1 : 16'sd0;
            B[x] = 16'(x + 1);
        end
        push_expected();
        send_frame(32, 32, to);
        total++; if (to !== 0) begin bad++; $display("FAIL ident_send timeouts %0d want 0", to); end
        collect(16, 1'b0);
        total++; if (tmo !== 0) begin bad++; $display("FAIL ident_timeout got %0d beats want 16", got34.size()); end
        for (int b = 0; b < got34.size(); b++) begin
            e34 = exp34.pop_front(); e32 = exp32.pop_front(); el = expl.pop_front();
            total++;
            if (got34[b] !== e34 || got32[b] !== e32 || gotl[b] !== el || got34[b] !== 34'(b + 1)) begin
                bad++; $display("FAIL ident beat %0d got %h/%h/%b want %h/%h/%b",
                    b, got34[b], got32[b], gotl[b], e34, e32, el);
            end
        end
        total++; if (dones !== 1) begin bad++; $display("FAIL ident_done pulses %0d want 1", dones); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ident_busy got %b want 0", busy); end
        exp34.delete(); exp32.delete(); expl.delete();
    endtask

    task automatic test_negative();
        int to;
        for (int x = 0; x < 16; x++) begin
            A[x] = -16'sd1;
            B[x] = 16'sd3;
        end
        push_expected();
        send_frame(32, 32, to);
        collect(16, 1'b0);
        total++; if (tmo !== 0 || to !== 0) begin bad++; $display("FAIL neg_timeout got %0d beats want 16", got34.size()); end
        for (int b = 0; b < got34.size(); b++) begin
            total++;
            if (got34[b] !== exp34.pop_front() || got34[b] !== 34'h3_FFFF_FFF4
                || got32[b] !== exp32.pop_front() || gotl[b] !== expl.pop_front()) begin
                bad++; $display("FAIL neg beat %0d got %h/%h want 3fffffff4/fffffff4", b, got34[b], got32[b]);
            end
        end
        exp34.delete(); exp32.delete(); expl.delete();
    endtask

    task automatic test_frame_err();
        int to, seen;
        for (int x = 0; x < 16; x++) begin
            A[x] = 16'($urandom);
            B[x] = 16'($urandom);
        end
        send_frame(5, 5, to);
        m_ready = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_valid) seen++;
            @(posedge clk);
            #1;
        end
        m_ready = 1'b0;
        total++; if (seen !== 0) begin bad++; $display("FAIL ferrA_valid cycles %0d want 0", seen); end
        total++; if (ferr !== 1'b1) begin bad++; $display("FAIL ferrA_flag got %b want 1", ferr); end
        total++; if (busy !== 1'b0 || s_ready !== 1'b1) begin bad++; $display("FAIL ferrA_idle busy %b ready %b want 0 1", busy, s_ready); end
        push_expected();
        send_frame(32, 32, to);
        total++; if (ferr !== 1'b0) begin bad++; $display("FAIL ferr_clear got %b want 0", ferr); end
        collect(16, 1'b0);
        total++; if (tmo !== 0 || to !== 0) begin bad++; $display("FAIL ferr_good_timeout got %0d beats want 16", got34.size()); end
        for (int b = 0; b < got34.size(); b++) begin
            total++;
            if (got34[b] !== exp34.pop_front() || got32[b] !== exp32.pop_front() || gotl[b] !== expl.pop_front()) begin
                bad++; $display("FAIL ferr_good beat %0d got %h/%h", b, got34[b], got32[b]);
            end
        end
        exp34.delete(); exp32.delete(); expl.delete();
        send_frame(20, 20, to);
        repeat (5) @(posedge clk);
        #1;
        total++; if (ferr !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL ferrB_flag got %b busy %b want 1 0", ferr, busy); end
        for (int x = 0; x < 16; x++) B[x] = 16'($urandom);
        push_expected();
        send_frame(0, 32, to);
        total++; if (ferr !== 1'b1) begin bad++; $display("FAIL ferr_nolast got %b want 1", ferr); end
        collect(16, 1'b0);
        total++; if (tmo !== 0) begin bad++; $display("FAIL ferr_nolast_timeout got %0d beats want 16", got34.size()); end
        for (int b = 0; b < got34.size(); b++) begin
            total++;
            if (got34[b] !== exp34.pop_front() || got32[b] !== exp32.pop_front() || gotl[b] !== expl.pop_front()) begin
                bad++; $display("FAIL ferr_nolast beat %0d got %h/%h", b, got34[b], got32[b]);
            end
        end
        exp34.delete(); exp32.delete(); expl.delete();
    endtask

    task automatic test_backpressure();
        int to;
        for (int x = 0; x < 16; x++) begin
            A[x] = 16'($urandom);
            B[x] = 16'($urandom);
        end
        push_expected();
        send_frame(32, 32, to);
        total++; if (ferr !== 1'b0) begin bad++; $display("FAIL bp_ferr got %b want 0", ferr); end
        collect(16, 1'b1);
        total++; if (tmo !== 0 || to !== 0) begin bad++; $display("FAIL bp_timeout got %0d beats want 16", got34.size()); end
        total++; if (held_bad !== 0) begin bad++; $display("FAIL bp_hold unstable stalls %0d want 0", held_bad); end
        total++; if (dones !== 1) begin bad++; $display("FAIL bp_done pulses %0d want 1", dones); end
        for (int b = 0; b < got34.size(); b++) begin
            total++;
            if (got34[b] !== exp34.pop_front() || got32[b] !== exp32.pop_front() || gotl[b] !== expl.pop_front()) begin
                bad++; $display("FAIL bp beat %0d got %h/%h/%b", b, got34[b], got32[b], gotl[b]);
            end
        end
        exp34.delete(); exp32.delete(); expl.delete();
    endtask

    task automatic test_saturate();
        int to;
        logic [31:0] want32;
`ifdef MATMUL_SATURATE_EN
        want32 = 32'h7FFF_FFFF;
`else
        want32 = 32'h0000_0000;
`endif
        for (int x = 0; x < 16; x++) begin
            A[x] = -16'sd32768;
            B[x] = -16'sd32768;
        end
        push_expected();
        send_frame(32, 32, to);
        collect(16, 1'b0);
        total++; if (tmo !== 0 || to !== 0) begin bad++; $display("FAIL sat_timeout got %0d beats want 16", got34.size()); end
        for (int b = 0; b < got34.size(); b++) begin
            total++;
            if (got34[b] !== 34'h1_0000_0000 || got32[b] !== want32
                || got34[b] !== exp34.pop_front() || got32[b] !== exp32.pop_front()) begin
                bad++; $display("FAIL sat beat %0d got %h/%h want 100000000/%h", b, got34[b], got32[b], want32);
            end
        end
        exp34.delete(); exp32.delete(); expl.delete();
    endtask

    task automatic test_reset_mid();
        int to, seen;
        for (int x = 0; x < 16; x++) begin
            A[x] = 16'($urandom);
            B[x] = 16'($urandom);
        end
        push_expected();
        send_frame(32, 32, to);
        collect(6, 1'b0);
        for (int b = 0; b < got34.size(); b++) begin
            total++;
            if (got34[b] !== exp34.pop_front() || got32[b] !== exp32.pop_front() || gotl[b] !== expl.pop_front()) begin
                bad++; $display("FAIL rmid beat %0d got %h/%h", b, got34[b], got32[b]);
            end
        end
        exp34.delete(); exp32.delete(); expl.delete();
        total++; if (m_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rmid_stall valid %b busy %b want 1 1", m_valid, busy); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({m_valid, m_last, busy, ferr, done, s_ready} !== 6'b000001 || m_data !== 34'd0) begin
            bad++; $display("FAIL rmid_reset got %b/%h want 000001/0", {m_valid, m_last, busy, ferr, done, s_ready}, m_data);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_valid || done) seen++;
            @(posedge clk);
            #1;
        end
        m_ready = 1'b0;
        total++; if (seen !== 0) begin bad++; $display("FAIL rmid_partial cycles %0d want 0", seen); end
        for (int x = 0; x < 16; x++) begin
            A[x] = 16'($urandom);
            B[x] = 16'($urandom);
        end
        push_expected();
        send_frame(32, 32, to);
        collect(16, 1'b0);
        total++; if (tmo !== 0 || to !== 0) begin bad++; $display("FAIL rmid_new_timeout got %0d beats want 16", got34.size()); end
        for (int b = 0; b < got34.size(); b++) begin
            total++;
            if (got34[b] !== exp34.pop_front() || got32[b] !== exp32.pop_front() || gotl[b] !== expl.pop_front()) begin
                bad++; $display("FAIL rmid_new beat %0d got %h/%h/%b", b, got34[b], got32[b], gotl[b]);
            end
        end
        exp34.delete(); exp32.delete(); expl.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_identity();
        test_negative();
        test_frame_err();
        test_backpressure();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
